perceptron_mac: RTL

PERCEPTRON_MAC -- requirements
Module: perceptron_mac

---
 rtl/perceptron_mac.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/perceptron_mac.sv
// perceptron_mac
//   Single-neuron perceptron evaluator. It accumulates N_INPUTS signed Q8.8
//   input/weight products on top of a Q8.8 bias, quantises the sum to a
//   10-bit sigmoid table address, reads the table and presents the result.
//
// Ports
//   clk_i, reset_i          clock; asynchronous active-low reset
//   start_i, bias_i         begin an evaluation (IDLE only); bias latched with it
//   x_valid_i/x_ready_o     handshake for one input/weight pair on x_i, w_i
//   lut_en_o, lut_we_o,     sigmoid table port (read-only use, registered
//   lut_addr_o, lut_di_o,   read data with one cycle of latency)
//   lut_dout_i
//   act_o, act_valid_o,     activation result handshake
//   act_ready_i
//   busy_o                  high whenever not IDLE
module perceptron_mac #(
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned ACC_W    = 40
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] bias_i,
  input  logic        x_valid_i,
  output logic        x_ready_o,
  input  logic [15:0] x_i,
  input  logic [15:0] w_i,
  output logic        lut_en_o,
  output logic        lut_we_o,
  output logic [9:0]  lut_addr_o,
  output logic [15:0] lut_di_o,
  input  logic [15:0] lut_dout_i,
  output logic [15:0] act_o,
  output logic        act_valid_o,
  input  logic        act_ready_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_QUANT,
    ST_LOOKUP,
    ST_CAPTURE,
    ST_OUT
  } state_t;

  // Quantised value range: [-8.0, +8.0) in steps of 1/64.
  localparam logic signed [ACC_W-1:0] T_MAX = ACC_W'(511);
  localparam logic signed [ACC_W-1:0] T_MIN = ACC_W'(-512);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [8:0]               cnt_q, cnt_d;
  logic [9:0]               addr_q, addr_d;
  logic [15:0]              act_q, act_d;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  t;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    act_d   = act_q;

    // Q8.8 * Q8.8 -> Q16.16, same scale as the accumulator.
    prod = $signed(x_i) * $signed(w_i);
    // Q.16 -> Q.6 (1/64 steps), arithmetic so negatives round toward -inf.
    t    = acc_q >>> 10;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Q8.8 bias moved to Q.16 by appending eight zero fraction bits.
          acc_d   = {{(ACC_W-24){bias_i[15]}}, bias_i, 8'h00};
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (x_valid_i) begin
          acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'(N_INPUTS - 1)) begin
            state_d = ST_QUANT;
          end
        end
      end
      ST_QUANT: begin
        if (t > T_MAX) begin
          addr_d = '1;
        end else if (t < T_MIN) begin
          addr_d = '0;
        end else begin
          // In range, t+512 is t's low ten bits with the sign bit flipped.
          addr_d = {~t[9], t[8:0]};
        end
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        act_d   = lut_dout_i;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (act_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
    end
  end

  // Control outputs decode straight from the state register so the
  // asynchronous reset clears them without waiting for a clock.
  assign x_ready_o   = (state_q == ST_ACC);
  assign lut_en_o    = (state_q == ST_LOOKUP);
  assign act_valid_o = (state_q == ST_OUT);
  assign busy_o      = (state_q != ST_IDLE);

  assign lut_we_o    = 1'b0;
  assign lut_di_o    = '0;
  assign lut_addr_o  = addr_q;
  assign act_o       = act_q;

endmodule
